id_ex_shift: RTL and testbench

ID_EX_SHIFT -- requirements
Module: id_ex_shift

---
 rtl/id_ex_shift_if.sv | 41 ++++
 rtl/id_ex_shift.sv | 101 ++++++++++
 tb/tb_id_ex_shift.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/id_ex_shift_if.sv
// ID/EX shift-stage bus: ID-side instruction fields, forwarding sources and
// the EX-side shifter operands. The stage itself takes the slave view.
interface id_ex_shift_if;
  logic        i_Valid;
  logic        i_Stall;
  logic        i_Flush;
  logic [4:0]  i_Shamt;
  logic        i_ShiftVar;
  logic [1:0]  i_OpSift;
  logic [4:0]  i_Rs;
  logic [4:0]  i_Rt;
  logic [4:0]  i_Rd;
  logic [31:0] i_RsData;
  logic [31:0] i_RtData;
  logic        i_ExMemWr;
  logic [4:0]  i_ExMemRd;
  logic [31:0] i_ExMemRes;
  logic        i_MemWbWr;
  logic [4:0]  i_MemWbRd;
  logic [31:0] i_MemWbRes;
  logic [4:0]  o_SA;
  logic [31:0] o_B;
  logic [1:0]  o_OpSift;
  logic [4:0]  o_Rd;
  logic        o_RegWr;
  logic        o_Valid;

  modport master (
    output i_Valid, i_Stall, i_Flush, i_Shamt, i_ShiftVar, i_OpSift,
           i_Rs, i_Rt, i_Rd, i_RsData, i_RtData,
           i_ExMemWr, i_ExMemRd, i_ExMemRes, i_MemWbWr, i_MemWbRd, i_MemWbRes,
    input  o_SA, o_B, o_OpSift, o_Rd, o_RegWr, o_Valid
  );

  modport slave (
    input  i_Valid, i_Stall, i_Flush, i_Shamt, i_ShiftVar, i_OpSift,
           i_Rs, i_Rt, i_Rd, i_RsData, i_RtData,
           i_ExMemWr, i_ExMemRd, i_ExMemRes, i_MemWbWr, i_MemWbRd, i_MemWbRes,
    output o_SA, o_B, o_OpSift, o_Rd, o_RegWr, o_Valid
  );
endinterface

// File: rtl/id_ex_shift.sv
// ID/EX pipeline register for shift-class instructions with EX/MEM and MEM/WB
// operand forwarding applied combinationally on the registered fields.
module id_ex_shift (
  input  logic         i_clk,
  input  logic         i_rst_n,
  id_ex_shift_if.slave bus
);

  logic        valid_q,     valid_d;
  logic [4:0]  shamt_q,     shamt_d;
  logic        shift_var_q, shift_var_d;
  logic [1:0]  op_q,        op_d;
  logic [4:0]  rs_q,        rs_d;
  logic [4:0]  rt_q,        rt_d;
  logic [4:0]  rd_q,        rd_d;
  // Only the low five bits of Rs can ever reach the shift amount.
  logic [4:0]  rs_sa_q,     rs_sa_d;
  logic [31:0] rt_data_q,   rt_data_d;

  logic unused_rs_data_hi;
  assign unused_rs_data_hi = ^bus.i_RsData[31:5];

  always_comb begin
    valid_d     = valid_q;
    shamt_d     = shamt_q;
    shift_var_d = shift_var_q;
    op_d        = op_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    rs_sa_d     = rs_sa_q;
    rt_data_d   = rt_data_q;
    if (bus.i_Flush) begin
      valid_d     = 1'b0;
      shamt_d     = '0;
      shift_var_d = 1'b0;
      op_d        = '0;
      rs_d        = '0;
      rt_d        = '0;
      rd_d        = '0;
      rs_sa_d     = '0;
      rt_data_d   = '0;
    end else if (!bus.i_Stall) begin
      valid_d     = bus.i_Valid;
      shamt_d     = bus.i_Shamt;
      shift_var_d = bus.i_ShiftVar;
      op_d        = bus.i_OpSift;
      rs_d        = bus.i_Rs;
      rt_d        = bus.i_Rt;
      rd_d        = bus.i_Rd;
      rs_sa_d     = bus.i_RsData[4:0];
      rt_data_d   = bus.i_RtData;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q     <= 1'b0;
      shamt_q     <= '0;
      shift_var_q <= 1'b0;
      op_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rs_sa_q     <= '0;
      rt_data_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      shamt_q     <= shamt_d;
      shift_var_q <= shift_var_d;
      op_q        <= op_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      rs_sa_q     <= rs_sa_d;
      rt_data_q   <= rt_data_d;
    end
  end

  // A source qualifies only with write enable set and a non-zero destination.
  logic ex_hit_rs, ex_hit_rt, wb_hit_rs, wb_hit_rt;
  assign ex_hit_rs = bus.i_ExMemWr && (bus.i_ExMemRd != 5'd0) && (bus.i_ExMemRd == rs_q);
  assign ex_hit_rt = bus.i_ExMemWr && (bus.i_ExMemRd != 5'd0) && (bus.i_ExMemRd == rt_q);
  assign wb_hit_rs = bus.i_MemWbWr && (bus.i_MemWbRd != 5'd0) && (bus.i_MemWbRd == rs_q);
  assign wb_hit_rt = bus.i_MemWbWr && (bus.i_MemWbRd != 5'd0) && (bus.i_MemWbRd == rt_q);

  logic [4:0]  fwd_rs_sa;
  logic [31:0] fwd_rt;
  assign fwd_rs_sa = ex_hit_rs ? bus.i_ExMemRes[4:0] :
                     wb_hit_rs ? bus.i_MemWbRes[4:0] : rs_sa_q;
  assign fwd_rt    = ex_hit_rt ? bus.i_ExMemRes :
                     wb_hit_rt ? bus.i_MemWbRes : rt_data_q;

  assign bus.o_SA     = shift_var_q ? fwd_rs_sa : shamt_q;
  assign bus.o_B      = fwd_rt;
  assign bus.o_OpSift = op_q;
  assign bus.o_Rd     = rd_q;
  assign bus.o_RegWr  = valid_q;
  assign bus.o_Valid  = valid_q;

endmodule

// File: tb/tb_id_ex_shift.sv
// Randomized bench for id_ex_shift: an EX-slot model plus directed literal
// checks for load, forwarding priority, r0, stall/flush and async reset.
module tb_id_ex_shift;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_shift_if bus ();
  id_ex_shift dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Contents of the EX slot as the instruction stream defines it.
  logic        m_valid, m_var;
  logic [4:0]  m_shamt, m_rs, m_rt, m_rd;
  logic [1:0]  m_op;
  logic [31:0] m_rsdata, m_rtdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.i_Flush) begin
      m_valid <= 0; m_var <= 0; m_shamt <= 0; m_rs <= 0; m_rt <= 0;
      m_rd <= 0; m_op <= 0; m_rsdata <= 0; m_rtdata <= 0;
    end else if (!bus.i_Stall) begin
      m_valid <= bus.i_Valid; m_var <= bus.i_ShiftVar; m_shamt <= bus.i_Shamt;
      m_rs <= bus.i_Rs; m_rt <= bus.i_Rt; m_rd <= bus.i_Rd; m_op <= bus.i_OpSift;
      m_rsdata <= bus.i_RsData; m_rtdata <= bus.i_RtData;
    end
  end

  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] d);
    if (r != 0 && bus.i_ExMemWr && bus.i_ExMemRd == r) return bus.i_ExMemRes;
    if (r != 0 && bus.i_MemWbWr && bus.i_MemWbRd == r) return bus.i_MemWbRes;
    return d;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [31:0] rs_val;
      logic [4:0]  exp_sa;
      rs_val = operand(m_rs, m_rsdata);
      exp_sa = m_var ? rs_val[4:0] : m_shamt;
      check("cyc_valid", {31'd0, bus.o_Valid}, {31'd0, m_valid});
      check("cyc_regwr", {31'd0, bus.o_RegWr}, {31'd0, m_valid});
      check("cyc_sa", {27'd0, bus.o_SA}, {27'd0, exp_sa});
      check("cyc_b", bus.o_B, operand(m_rt, m_rtdata));
      check("cyc_op", {30'd0, bus.o_OpSift}, {30'd0, m_op});
      check("cyc_rd", {27'd0, bus.o_Rd}, {27'd0, m_rd});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_Valid = 0; bus.i_Stall = 0; bus.i_Flush = 0; bus.i_Shamt = 0;
    bus.i_ShiftVar = 0; bus.i_OpSift = 0; bus.i_Rs = 0; bus.i_Rt = 0; bus.i_Rd = 0;
    bus.i_RsData = 0; bus.i_RtData = 0;
    bus.i_ExMemWr = 0; bus.i_ExMemRd = 0; bus.i_ExMemRes = 0;
    bus.i_MemWbWr = 0; bus.i_MemWbRd = 0; bus.i_MemWbRes = 0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] sh, input logic var_s,
                        input logic [1:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd);
    bus.i_Valid = v; bus.i_Shamt = sh; bus.i_ShiftVar = var_s; bus.i_OpSift = op;
    bus.i_Rs = rs; bus.i_Rt = rt; bus.i_Rd = rd; bus.i_RsData = rsd; bus.i_RtData = rtd;
  endtask

  function automatic logic [4:0] pick_rd();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return m_rs;
      2: return m_rt;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, bus.o_Valid}, 32'd0);
    check("rst_regwr", {31'd0, bus.o_RegWr}, 32'd0);
    check("rst_sa", {27'd0, bus.o_SA}, 32'd0);
    check("rst_b", bus.o_B, 32'd0);
    check("rst_op", {30'd0, bus.o_OpSift}, 32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Plain sll load.
    set_id(1, 5'd4, 0, 2'd0, 5'd3, 5'd8, 5'd9, 32'h0000_0123, 32'h0000_0001);
    step();
    check("load_b", bus.o_B, 32'h0000_0001);
    check("load_sa", {27'd0, bus.o_SA}, 32'd4);
    check("load_op", {30'd0, bus.o_OpSift}, 32'd0);
    check("load_valid", {31'd0, bus.o_Valid}, 32'd1);
    check("load_rd", {27'd0, bus.o_Rd}, 32'd9);

    // Both forwarding sources target Rt.
    set_id(1, 5'd0, 0, 2'd1, 5'd1, 5'd8, 5'd2, 32'h0, 32'h0000_1234);
    step();
    bus.i_ExMemWr = 1; bus.i_ExMemRd = 5'd8; bus.i_ExMemRes = 32'hAAAA_0000;
    bus.i_MemWbWr = 1; bus.i_MemWbRd = 5'd8; bus.i_MemWbRes = 32'h5555_0000;
    #1;
    check("fwd_prio_b", bus.o_B, 32'hAAAA_0000);
    bus.i_ExMemWr = 0;
    #1;
    check("fwd_wb_b", bus.o_B, 32'h5555_0000);
    clear_inputs();

    // srav with Rs = r0 and an EX/MEM writer claiming r0.
    set_id(1, 5'd3, 1, 2'd2, 5'd0, 5'd5, 5'd6, 32'hFFFF_FFE7, 32'h8000_0000);
    bus.i_ExMemWr = 1; bus.i_ExMemRd = 5'd0; bus.i_ExMemRes = 32'h0000_001F;
    step();
    check("r0_sa", {27'd0, bus.o_SA}, 32'd7);
    check("r0_op", {30'd0, bus.o_OpSift}, 32'd2);
    clear_inputs();

    // Stall for three cycles with a changing ID input, then stall + flush.
    set_id(1, 5'd9, 0, 2'd3, 5'd1, 5'd2, 5'd4, 32'h0, 32'h0000_0077);
    step();
    for (int i = 0; i < 3; i++) begin
      set_id(1, 5'(i + 20), 0, 2'd1, 5'(i + 10), 5'(i + 11), 5'(i + 12), 32'(i), 32'hDEAD_0000 + 32'(i));
      bus.i_Stall = 1;
      step();
      check("stall_b", bus.o_B, 32'h0000_0077);
      check("stall_sa", {27'd0, bus.o_SA}, 32'd9);
      check("stall_valid", {31'd0, bus.o_Valid}, 32'd1);
    end
    bus.i_Flush = 1;
    step();
    check("flush_valid", {31'd0, bus.o_Valid}, 32'd0);
    check("flush_regwr", {31'd0, bus.o_RegWr}, 32'd0);
    clear_inputs();

    // Asynchronous reset between edges, then a normal load after release.
    set_id(1, 5'd5, 0, 2'd0, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0000_00AB);
    step();
    check("pre_arst_valid", {31'd0, bus.o_Valid}, 32'd1);
    set_id(1, 5'd6, 0, 2'd1, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0000_CAFE);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus.o_Valid}, 32'd0);
    check("arst_regwr", {31'd0, bus.o_RegWr}, 32'd0);
    #2 rst_n = 1'b1;
    step();
    check("post_arst_b", bus.o_B, 32'h0000_CAFE);
    check("post_arst_valid", {31'd0, bus.o_Valid}, 32'd1);
    check("post_arst_rd", {27'd0, bus.o_Rd}, 32'd7);

    for (int n = 0; n < 3000; n++) begin
      set_id(1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 1)),
             2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom);
      bus.i_Stall = ($urandom_range(0, 4) == 0);
      bus.i_Flush = ($urandom_range(0, 9) == 0);
      bus.i_ExMemWr = 1'($urandom_range(0, 1)); bus.i_ExMemRd = pick_rd(); bus.i_ExMemRes = $urandom;
      bus.i_MemWbWr = 1'($urandom_range(0, 1)); bus.i_MemWbRd = pick_rd(); bus.i_MemWbRes = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        check("rand_arst_valid", {31'd0, bus.o_Valid}, 32'd0);
        rst_n = 1'b1;
      end
      step();
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
